// File: rtl/aclock_set_if.sv
// Button inputs and BCD digit / load-strobe outputs of the aclock time/alarm entry controller.
interface aclock_set_if;
    logic       btn_mode;
    logic       btn_inc;
    logic       btn_set;
    logic       sel_alarm;
    logic [1:0] H_in1;
    logic [3:0] H_in0;
    logic [3:0] M_in1;
    logic [3:0] M_in0;
    logic       LD_time;
    logic       LD_alarm;
    logic       edit_active;
    logic [3:0] cursor;

    modport master (
        output btn_mode, btn_inc, btn_set, sel_alarm,
        input  H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, edit_active, cursor
    );

    modport slave (
        input  btn_mode, btn_inc, btn_set, sel_alarm,
        output H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, edit_active, cursor
    );
endinterface

// File: rtl/aclock_set_ctrl.sv
// Turns three raw buttons into legal 24-hour BCD digits plus one-cycle LD_time/LD_alarm strobes:
// per-button synchroniser and debounce, digit-cursor FSM, BCD increment with wrap and clamp.
module aclock_set_ctrl #(
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int TIMEOUT_CYCLES  = 200
) (
    input  logic        clk,
    input  logic        reset,
    aclock_set_if.slave bus_if
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_EDIT_H1,
        S_EDIT_H0,
        S_EDIT_M1,
        S_EDIT_M0,
        S_COMMIT
    } state_e;

    localparam int BTN_MODE = 0;
    localparam int BTN_INC  = 1;
    localparam int BTN_SET  = 2;

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [2:0]      raw;
    logic [2:0]      sync1_q, sync2_q;
    logic [2:0]      db_q, db_d;
    logic [2:0]      press_q, press_d;
    logic [DB_W-1:0] cnt_q [3];
    logic [DB_W-1:0] cnt_d [3];

    assign raw = {bus_if.btn_set, bus_if.btn_inc, bus_if.btn_mode};

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
        db_d    = db_q;
        press_d = '0;
        for (int b = 0; b < 3; b++) begin
            cnt_d[b] = '0;
            // A gap in the mismatch leaves cnt_d at zero, restarting the count.
            if (sync2_q[b] != db_q[b]) begin
                if (cnt_q[b] == DB_LAST) begin
                    db_d[b]    = sync2_q[b];
                    press_d[b] = sync2_q[b];
                end else begin
                    cnt_d[b] = cnt_q[b] + DB_W'(1);
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, independent of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            press_q <= '0;
            // NOTE: this counter array is three small registers, not a RAM, so clearing it in reset is cheap and required.
            for (int b = 0; b < 3; b++) cnt_q[b] <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    // Priority SET > MODE > INC; lower-priority events in the same cycle are dropped.
    logic ev_set, ev_mode, ev_inc, any_ev;
    assign ev_set  = press_q[BTN_SET];
    assign ev_mode = press_q[BTN_MODE] & ~press_q[BTN_SET];
    assign ev_inc  = press_q[BTN_INC] & ~press_q[BTN_SET] & ~press_q[BTN_MODE];
    assign any_ev  = |press_q;

    // ------------------------------------------------------------------
    // Cursor FSM
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    logic             is_edit;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    assign is_edit = state_q inside {S_EDIT_H1, S_EDIT_H0, S_EDIT_M1, S_EDIT_M0};
    assign tmo_d   = (is_edit && !any_ev) ? tmo_q + TMO_W'(1) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (ev_mode) state_d = S_EDIT_H1;
            S_EDIT_H1, S_EDIT_H0, S_EDIT_M1, S_EDIT_M0: begin
                if (ev_set) begin
                    state_d = S_COMMIT;
                end else if (ev_mode) begin
                    case (state_q)
                        S_EDIT_H1: state_d = S_EDIT_H0;
                        S_EDIT_H0: state_d = S_EDIT_M1;
                        S_EDIT_M1: state_d = S_EDIT_M0;
                        default:   state_d = S_EDIT_H1;
                    endcase
                end else if (!any_ev && tmo_q == TMO_LAST) begin
                    state_d = S_IDLE;
                end
            end
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Working digits and target
    // ------------------------------------------------------------------
    logic [1:0] h1_q, h1_d;
    logic [3:0] h0_q, h0_d, m1_q, m1_d, m0_q, m0_d;
    logic       target_q, target_d;

    always_comb begin
        h1_d     = h1_q;
        h0_d     = h0_q;
        m1_d     = m1_q;
        m0_d     = m0_q;
        target_d = target_q;
        if (state_q == S_IDLE && ev_mode) target_d = bus_if.sel_alarm;
        if (ev_inc) begin
            case (state_q)
                S_EDIT_H1: begin
                    if (h1_q == 2'd2) begin
                        h1_d = 2'd0;
                    end else begin
                        h1_d = h1_q + 2'd1;
                        // Entering the 20s: hours units above 3 would be illegal.
                        if (h1_q == 2'd1 && h0_q > 4'd3) h0_d = 4'd3;
                    end
                end
                S_EDIT_H0: h0_d = (h0_q == ((h1_q == 2'd2) ? 4'd3 : 4'd9)) ? 4'd0 : h0_q + 4'd1;
                S_EDIT_M1: m1_d = (m1_q == 4'd5) ? 4'd0 : m1_q + 4'd1;
                S_EDIT_M0: m0_d = (m0_q == 4'd9) ? 4'd0 : m0_q + 4'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h1_q     <= '0;
            h0_q     <= '0;
            m1_q     <= '0;
            m0_q     <= '0;
            target_q <= 1'b0;
        end else begin
            h1_q     <= h1_d;
            h0_q     <= h0_d;
            m1_q     <= m1_d;
            m0_q     <= m0_d;
            target_q <= target_d;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs, decoded from the next state
    // ------------------------------------------------------------------
    logic       edit_active_q, edit_active_d;
    logic [3:0] cursor_q, cursor_d;
    logic       ld_time_q, ld_time_d;
    logic       ld_alarm_q, ld_alarm_d;

    always_comb begin
        edit_active_d = 1'b0;
        cursor_d      = 4'b0000;
        ld_time_d     = 1'b0;
        ld_alarm_d    = 1'b0;
        case (state_d)
            S_EDIT_H1: begin edit_active_d = 1'b1; cursor_d = 4'b1000; end
            S_EDIT_H0: begin edit_active_d = 1'b1; cursor_d = 4'b0100; end
            S_EDIT_M1: begin edit_active_d = 1'b1; cursor_d = 4'b0010; end
            S_EDIT_M0: begin edit_active_d = 1'b1; cursor_d = 4'b0001; end
            S_COMMIT: begin
                ld_time_d  = ~target_d;
                ld_alarm_d = target_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            edit_active_q <= 1'b0;
            cursor_q      <= '0;
            ld_time_q     <= 1'b0;
            ld_alarm_q    <= 1'b0;
        end else begin
            edit_active_q <= edit_active_d;
            cursor_q      <= cursor_d;
            ld_time_q     <= ld_time_d;
            ld_alarm_q    <= ld_alarm_d;
        end
    end

    assign bus_if.H_in1       = h1_q;
    assign bus_if.H_in0       = h0_q;
    assign bus_if.M_in1       = m1_q;
    assign bus_if.M_in0       = m0_q;
    assign bus_if.LD_time     = ld_time_q;
    assign bus_if.LD_alarm    = ld_alarm_q;
    assign bus_if.edit_active = edit_active_q;
    assign bus_if.cursor      = cursor_q;
endmodule

// File: tb/tb_aclock_set_ctrl.sv
// Self-checking bench for aclock_set_ctrl: directed entry scenarios plus random button traffic,
// all outputs compared every cycle against an event-level model of the entry rules.
module tb_aclock_set_ctrl;
    localparam int D = 3;
    localparam int T = 200;

    logic clk = 1'b0;
    logic reset;
    aclock_set_if bus_if();

    aclock_set_ctrl #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T)) dut (
        .clk   (clk),
        .reset (reset),
        .bus_if(bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int ld_time_seen  = 0;
    int ld_alarm_seen = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: button index 0=mode 1=inc 2=set; digits 0=H1 1=H0 2=M1 3=M0
    // ------------------------------------------------------------------
    bit hist [3][D+2];      // raw samples, [0] = newest edge
    bit m_db [3];
    bit m_press [3];        // press events visible to the controller on the next edge
    bit m_editing = 0;
    bit m_commit  = 0;
    bit m_target  = 0;
    int m_cur     = 0;
    int m_quiet   = 0;
    int m_dig [4] = '{0, 0, 0, 0};

    function automatic void bump(int c);
        case (c)
            0: begin
                if (m_dig[0] == 2) m_dig[0] = 0;
                else begin
                    m_dig[0]++;
                    if (m_dig[0] == 2 && m_dig[1] > 3) m_dig[1] = 3;
                end
            end
            1: m_dig[1] = (m_dig[1] + 1) % ((m_dig[0] == 2) ? 4 : 10);
            2: m_dig[2] = (m_dig[2] + 1) % 6;
            default: m_dig[3] = (m_dig[3] + 1) % 10;
        endcase
    endfunction

    task automatic model_step();
        bit raw [3];
        bit ev_set, ev_mode, ev_inc, all_differ;
        raw[0] = bus_if.btn_mode;
        raw[1] = bus_if.btn_inc;
        raw[2] = bus_if.btn_set;
        if (reset) begin
            for (int b = 0; b < 3; b++) begin
                for (int k = 0; k < D + 2; k++) hist[b][k] = 0;
                m_db[b] = 0;
                m_press[b] = 0;
            end
            m_editing = 0; m_commit = 0; m_target = 0; m_cur = 0; m_quiet = 0;
            for (int i = 0; i < 4; i++) m_dig[i] = 0;
            return;
        end
        ev_set  = m_press[2];
        ev_mode = m_press[0] && !ev_set;
        ev_inc  = m_press[1] && !m_press[0] && !ev_set;
        if (m_commit) begin
            m_commit = 0;
        end else if (!m_editing) begin
            if (ev_mode) begin
                m_editing = 1; m_cur = 0; m_quiet = 0; m_target = bus_if.sel_alarm;
            end
        end else if (ev_set) begin
            m_editing = 0; m_commit = 1;
        end else if (ev_mode) begin
            m_cur = (m_cur + 1) % 4; m_quiet = 0;
        end else if (ev_inc) begin
            bump(m_cur); m_quiet = 0;
        end else begin
            m_quiet++;
            if (m_quiet == T) m_editing = 0;
        end
        // Debounced level follows the synchronised input (raw delayed 2 edges) once it has differed D edges in a row.
        for (int b = 0; b < 3; b++) begin
            for (int k = D + 1; k > 0; k--) hist[b][k] = hist[b][k-1];
            hist[b][0] = raw[b];
            all_differ = 1;
            for (int k = 2; k < D + 2; k++) if (hist[b][k] == m_db[b]) all_differ = 0;
            m_press[b] = 0;
            if (all_differ) begin
                m_db[b] = !m_db[b];
                m_press[b] = m_db[b];
            end
        end
    endtask

    function automatic logic [31:0] model_outputs();
        logic [3:0] cur;
        cur = m_editing ? (4'b1000 >> m_cur) : 4'b0000;
        return 32'({2'(m_dig[0]), 4'(m_dig[1]), 4'(m_dig[2]), 4'(m_dig[3]),
                    m_commit && !m_target, m_commit && m_target, m_editing, cur});
    endfunction

    function automatic logic [31:0] dut_outputs();
        return 32'({bus_if.H_in1, bus_if.H_in0, bus_if.M_in1, bus_if.M_in0,
                    bus_if.LD_time, bus_if.LD_alarm, bus_if.edit_active, bus_if.cursor});
    endfunction

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        check("outputs_vs_model", dut_outputs(), model_outputs());
        if (bus_if.LD_time === 1'b1)  ld_time_seen++;
        if (bus_if.LD_alarm === 1'b1) ld_alarm_seen++;
    end

    // ------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------
    task automatic push(input bit m, input bit i, input bit s);
        @(negedge clk);
        bus_if.btn_mode = m; bus_if.btn_inc = i; bus_if.btn_set = s;
        repeat (D + 4) @(negedge clk);
        bus_if.btn_mode = 0; bus_if.btn_inc = 0; bus_if.btn_set = 0;
        repeat (D + 4) @(negedge clk);
    endtask

    task automatic push_n(input bit m, input bit i, input int n);
        for (int k = 0; k < n; k++) push(m, i, 1'b0);
    endtask

    task automatic check_digits(input string name, input int h1, input int h0, input int m1, input int m0);
        check(name, 32'({bus_if.H_in1, bus_if.H_in0, bus_if.M_in1, bus_if.M_in0}),
              32'({2'(h1), 4'(h0), 4'(m1), 4'(m0)}));
    endtask

    int t0, a0;
    bit found;
    logic [2:0] btn_rand;
    int hold [3];

    initial begin
        reset = 1'b1;
        bus_if.btn_mode = 0; bus_if.btn_inc = 0; bus_if.btn_set = 0; bus_if.sel_alarm = 0;
        repeat (3) @(negedge clk);
        check("reset_outputs", dut_outputs(), 32'd0);
        reset = 1'b0;

        // Two-cycle glitch must not produce an event.
        bus_if.btn_mode = 1;
        repeat (2) @(negedge clk);
        bus_if.btn_mode = 0;
        repeat (D + 8) @(negedge clk);
        check("glitch_no_edit", 32'(bus_if.edit_active), 32'd0);

        // Time entry 14:26.
        bus_if.sel_alarm = 0;
        push(1, 0, 0); push_n(0, 1, 1);
        push(1, 0, 0); push_n(0, 1, 4);
        push(1, 0, 0); push_n(0, 1, 2);
        push(1, 0, 0); push_n(0, 1, 6);
        t0 = ld_time_seen; a0 = ld_alarm_seen;
        push(0, 0, 1);
        check_digits("time_1426", 1, 4, 2, 6);
        check("time_ld_time_pulses", 32'(ld_time_seen - t0), 32'd1);
        check("time_ld_alarm_pulses", 32'(ld_alarm_seen - a0), 32'd0);
        check("time_idle_after", 32'({bus_if.edit_active, bus_if.cursor}), 32'd0);

        // Alarm entry 09:55 from 14:26, passing through the H1 clamp.
        bus_if.sel_alarm = 1;
        push(1, 0, 0);
        bus_if.sel_alarm = 0;
        push_n(0, 1, 1);
        check_digits("clamp_2326", 2, 3, 2, 6);
        push_n(0, 1, 1);
        check_digits("h1_wrap_0326", 0, 3, 2, 6);
        push(1, 0, 0); push_n(0, 1, 6);
        push(1, 0, 0); push_n(0, 1, 3);
        push(1, 0, 0); push_n(0, 1, 9);
        t0 = ld_time_seen; a0 = ld_alarm_seen;
        push(0, 0, 1);
        check_digits("alarm_0955", 0, 9, 5, 5);
        check("alarm_ld_alarm_pulses", 32'(ld_alarm_seen - a0), 32'd1);
        check("alarm_ld_time_pulses", 32'(ld_time_seen - t0), 32'd0);

        // Wrap and clamp walk.
        push(1, 0, 0);
        push_n(0, 1, 1); check_digits("wrap_1955", 1, 9, 5, 5);
        push_n(0, 1, 1); check_digits("wrap_2355", 2, 3, 5, 5);
        push(1, 0, 0); push_n(0, 1, 1); check_digits("wrap_2055", 2, 0, 5, 5);
        push(1, 0, 0); push_n(0, 1, 1); check_digits("wrap_2005", 2, 0, 0, 5);
        push(1, 0, 0); push(1, 0, 0); push_n(0, 1, 1); check_digits("wrap_0005", 0, 0, 0, 5);
        push(0, 0, 1);

        // Timeout: edit M0 then leave the buttons alone.
        push(1, 0, 0); push_n(1, 0, 3); push_n(0, 1, 1);
        check("timeout_still_editing", 32'({bus_if.edit_active, bus_if.cursor}), 32'h11);
        t0 = ld_time_seen; a0 = ld_alarm_seen;
        repeat (T + 20) @(negedge clk);
        check("timeout_idle", 32'(bus_if.edit_active), 32'd0);
        check_digits("timeout_digits_kept", 0, 0, 0, 6);
        check("timeout_no_strobe", 32'((ld_time_seen - t0) + (ld_alarm_seen - a0)), 32'd0);

        // Same-cycle SET and INC in EDIT_M0: commit without increment.
        push(1, 0, 0); push_n(1, 0, 3);
        t0 = ld_time_seen;
        push(0, 1, 1);
        check_digits("set_beats_inc", 0, 0, 0, 6);
        check("set_beats_inc_strobe", 32'(ld_time_seen - t0), 32'd1);

        // Reset sampled on the edge that accepts SET: no strobe, all outputs zero.
        push(1, 0, 0);
        @(negedge clk);
        bus_if.btn_set = 1;
        found = 0;
        for (int k = 0; k < 4 * D + 10 && !found; k++) begin
            @(negedge clk);
            if (m_press[2]) found = 1;
        end
        check("set_event_seen", 32'(found), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("reset_in_commit_outputs", dut_outputs(), 32'd0);
        reset = 1'b0;
        bus_if.btn_set = 0;
        repeat (D + 4) @(negedge clk);

        // Random button traffic with occasional resets.
        for (int b = 0; b < 3; b++) hold[b] = 0;
        btn_rand = '0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            for (int b = 0; b < 3; b++) begin
                if (hold[b] == 0) begin
                    btn_rand[b] = 1'($urandom_range(0, 1));
                    hold[b] = $urandom_range(1, 3 * D + 6);
                end else begin
                    hold[b]--;
                end
            end
            bus_if.btn_mode = btn_rand[0];
            bus_if.btn_inc  = btn_rand[1];
            bus_if.btn_set  = btn_rand[2];
            if ($urandom_range(0, 7) == 0) bus_if.sel_alarm = 1'($urandom_range(0, 1));
            reset = ($urandom_range(0, 999) == 0);
        end
        @(negedge clk);
        reset = 1'b0;
        bus_if.btn_mode = 0; bus_if.btn_inc = 0; bus_if.btn_set = 0;
        repeat (D + 6) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
